// File: rtl/uart_sim_pkg.sv
// Shared types and helpers for the simulation-side UART input responder.
//   uart_char_t   : one UART character
//   UART_IDLE_CH  : value returned when no character is queued
//   sat_inc       : increment that sticks at the all-ones value of a given width (w <= 32)
package uart_sim_pkg;

    typedef logic [7:0] uart_char_t;

    localparam uart_char_t UART_IDLE_CH = 8'hff;

    // Saturating increment of the low w bits of v.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/uart_in_responder_if.sv
// Handshake bundle between host stimulus / SoC UART reader and the responder.
//   host_valid/host_ch/host_ready : host push channel
//   io_uart_in_valid/io_uart_in_ch: SoC UART read strobe and returned character
//   master : stimulus side (drives valids and host data)
//   slave  : responder side (drives host_ready and the returned character)
interface uart_in_responder_if;

    logic                    host_valid;
    uart_sim_pkg::uart_char_t host_ch;
    logic                    host_ready;
    logic                    io_uart_in_valid;
    uart_sim_pkg::uart_char_t io_uart_in_ch;

    modport master (
        output host_valid,
        output host_ch,
        output io_uart_in_valid,
        input  host_ready,
        input  io_uart_in_ch
    );

    modport slave (
        input  host_valid,
        input  host_ch,
        input  io_uart_in_valid,
        output host_ready,
        output io_uart_in_ch
    );

endinterface

// File: rtl/sim_sync_fifo.sv
// Single-clock DEPTH x 8 FIFO with wrap-bit pointers.
//   clock, reset_n : clock and asynchronous active-low reset (clears pointers)
//   push, din      : write din when push and not full
//   pop            : advance read pointer when pop and not empty
//   full, empty    : derived from registered pointers only
//   count          : occupancy 0..DEPTH
//   head           : raw storage at the read pointer (undefined content when empty)
module sim_sync_fifo
    import uart_sim_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  uart_char_t    din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count,
    output uart_char_t    head
);

    uart_char_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Modulo 2^PW subtraction gives the occupancy across pointer wrap.
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer registers; reset discards all queued entries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_in_responder.sv
// Simulation-side responder for the SoC UART input channel.
// Host pushes characters into a FIFO; each cycle io_uart_in_valid is high the
// FIFO head is returned combinationally and popped, or IDLE_CH when empty.
//   clock, reset_n  : clock and asynchronous active-low reset
//   bus             : host push channel and UART read channel (slave side)
//   fifo_count      : current occupancy
//   rd_count        : successful reads, saturating
//   underflow_count : reads while empty, saturating
module uart_in_responder
    import uart_sim_pkg::*;
#(
    parameter  int unsigned DEPTH   = 16,
    parameter  uart_char_t  IDLE_CH = UART_IDLE_CH,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned PW      = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    uart_in_responder_if.slave   bus,
    output logic [PW-1:0]        fifo_count,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     underflow_count
);

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    uart_char_t head;

    // host_ready depends only on pointer state, never on the read strobe.
    assign bus.host_ready    = !full;
    assign push              = bus.host_valid && !full;
    assign pop               = bus.io_uart_in_valid && !empty;
    // No write-to-read bypass: a push in the same cycle is not visible yet.
    assign bus.io_uart_in_ch = empty ? IDLE_CH : head;

    sim_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (bus.host_ch),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count),
        .head    (head)
    );

    // Read statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_count        <= '0;
            underflow_count <= '0;
        end else begin
            if (pop) begin
                rd_count <= CNT_W'(sat_inc(32'(rd_count), CNT_W));
            end
            if (bus.io_uart_in_valid && empty) begin
                underflow_count <= CNT_W'(sat_inc(32'(underflow_count), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_uart_in_responder.sv
// Directed bench for uart_in_responder: inputs change 1 time unit after the
// rising edge, outputs are checked at the falling edge.
module tb_uart_in_responder;

    logic        clock;
    logic        reset_n;
    logic [4:0]  fifo_count;
    logic [15:0] rd_count;
    logic [15:0] underflow_count;

    int n_tests;
    int n_fail;

    uart_in_responder_if bus();

    uart_in_responder #(
        .DEPTH   (16),
        .IDLE_CH (8'hff),
        .CNT_W   (16)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bus),
        .fifo_count      (fifo_count),
        .rd_count        (rd_count),
        .underflow_count (underflow_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] ch);
        bus.host_valid = 1'b1;
        bus.host_ch    = ch;
        step();
        bus.host_valid = 1'b0;
    endtask

    initial begin
        int m_count;
        int pushed;
        int reads;
        int cyc;
        logic do_push;
        logic do_pop;

        n_tests = 0;
        n_fail  = 0;
        bus.host_valid       = 1'b0;
        bus.host_ch          = 8'h00;
        bus.io_uart_in_valid = 1'b0;
        reset_n = 1'b0;

        // Reset values
        #3;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(bus.host_ready), 32'd1);
        check("rst_ch", 32'(bus.io_uart_in_ch), 32'hff);
        check("rst_rd", 32'(rd_count), 32'd0);
        check("rst_uf", 32'(underflow_count), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // 1: strobe while empty
        bus.io_uart_in_valid = 1'b1;
        @(negedge clock);
        check("t1_ch", 32'(bus.io_uart_in_ch), 32'hff);
        step();
        bus.io_uart_in_valid = 1'b0;
        check("t1_uf", 32'(underflow_count), 32'd1);
        check("t1_rd", 32'(rd_count), 32'd0);

        // 2: push "hi" and read it back
        push(8'h68);
        push(8'h69);
        check("t2_cnt2", 32'(fifo_count), 32'd2);
        bus.io_uart_in_valid = 1'b1;
        @(negedge clock);
        check("t2_ch0", 32'(bus.io_uart_in_ch), 32'h68);
        step();
        check("t2_cnt1", 32'(fifo_count), 32'd1);
        @(negedge clock);
        check("t2_ch1", 32'(bus.io_uart_in_ch), 32'h69);
        step();
        check("t2_cnt0", 32'(fifo_count), 32'd0);
        @(negedge clock);
        check("t2_ch2", 32'(bus.io_uart_in_ch), 32'hff);
        step();
        bus.io_uart_in_valid = 1'b0;
        check("t2_rd", 32'(rd_count), 32'd2);
        check("t2_uf", 32'(underflow_count), 32'd2);

        // 3: fill, then pop with a refused push
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t3_full_ready", 32'(bus.host_ready), 32'd0);
        check("t3_full_cnt", 32'(fifo_count), 32'd16);
        bus.io_uart_in_valid = 1'b1;
        bus.host_valid       = 1'b1;
        bus.host_ch          = 8'h10;
        @(negedge clock);
        check("t3_ch", 32'(bus.io_uart_in_ch), 32'h00);
        step();
        bus.io_uart_in_valid = 1'b0;
        bus.host_valid       = 1'b0;
        check("t3_cnt15", 32'(fifo_count), 32'd15);
        check("t3_ready", 32'(bus.host_ready), 32'd1);
        bus.io_uart_in_valid = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            check("t3_drain", 32'(bus.io_uart_in_ch), 32'(i));
            step();
        end
        bus.io_uart_in_valid = 1'b0;
        check("t3_empty", 32'(fifo_count), 32'd0);
        check("t3_rd", 32'(rd_count), 32'd18);

        // 4: interleaved pushes/pops across pointer wrap
        m_count = 0;
        pushed  = 0;
        reads   = 0;
        cyc     = 0;
        while (reads < 40 && cyc < 400) begin
            do_push = (pushed < 40) && (cyc % 3 != 2) && (m_count < 16);
            do_pop  = (m_count > 0) && ((cyc % 2 == 1) || (pushed == 40));
            bus.host_valid       = do_push;
            bus.host_ch          = 8'(pushed);
            bus.io_uart_in_valid = do_pop;
            @(negedge clock);
            check("t4_cnt", 32'(fifo_count), 32'(m_count));
            check("t4_ready", 32'(bus.host_ready), 32'(m_count < 16));
            if (do_pop) check("t4_ch", 32'(bus.io_uart_in_ch), 32'(reads));
            step();
            if (do_push) begin pushed++; m_count++; end
            if (do_pop)  begin reads++;  m_count--; end
            cyc++;
        end
        bus.host_valid       = 1'b0;
        bus.io_uart_in_valid = 1'b0;
        check("t4_reads", 32'(reads), 32'd40);
        check("t4_end_cnt", 32'(fifo_count), 32'd0);
        check("t4_rd", 32'(rd_count), 32'd58);

        // 5: push and strobe together while empty
        bus.host_valid       = 1'b1;
        bus.host_ch          = 8'h41;
        bus.io_uart_in_valid = 1'b1;
        @(negedge clock);
        check("t5_ch_idle", 32'(bus.io_uart_in_ch), 32'hff);
        step();
        bus.host_valid = 1'b0;
        check("t5_uf", 32'(underflow_count), 32'd3);
        @(negedge clock);
        check("t5_ch", 32'(bus.io_uart_in_ch), 32'h41);
        step();
        bus.io_uart_in_valid = 1'b0;
        check("t5_rd", 32'(rd_count), 32'd59);
        check("t5_cnt", 32'(fifo_count), 32'd0);

        // 6: reset with characters queued
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        check("t6_cnt5", 32'(fifo_count), 32'd5);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t6_cnt", 32'(fifo_count), 32'd0);
        check("t6_ready", 32'(bus.host_ready), 32'd1);
        check("t6_ch", 32'(bus.io_uart_in_ch), 32'hff);
        check("t6_rd", 32'(rd_count), 32'd0);
        check("t6_uf", 32'(underflow_count), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        bus.io_uart_in_valid = 1'b1;
        @(negedge clock);
        check("t6_post_ch", 32'(bus.io_uart_in_ch), 32'hff);
        step();
        bus.io_uart_in_valid = 1'b0;
        check("t6_post_uf", 32'(underflow_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
